// File: rtl/bus_transfer_ctrl.sv
// Bus master for the shared CPU data bus: copies one word between two bus-attached registers
// by stepping the one-hot output-enable/load-enable strobes on each tick.
module bus_transfer_ctrl #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DATA_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                hlt,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_src,
  input  logic [SEL_W-1:0]    req_dst,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [NUM_REGS-1:0] out_en,
  output logic [NUM_REGS-1:0] load_en,
  output logic [DATA_W-1:0]   last_data,
  output logic                done,
  output logic                err
);

  localparam int unsigned SEL_SPACE = 1 << SEL_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Marks which select codes address a real register.
  function automatic logic [SEL_SPACE-1:0] build_idx_ok();
    logic [SEL_SPACE-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SEL_SPACE; i++) begin
      m[i] = (i < NUM_REGS);
    end
    return m;
  endfunction

  localparam logic [SEL_SPACE-1:0] IDX_OK = build_idx_ok();

  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      src_q, src_d;
  logic [SEL_W-1:0]      dst_q, dst_d;
  logic [NUM_REGS-1:0]   out_en_q, out_en_d;
  logic [NUM_REGS-1:0]   load_en_q, load_en_d;
  logic [DATA_W-1:0]     last_data_q, last_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  accept;
  logic                  req_bad;

  // Ready is a registered "in IDLE" flag, gated live by hlt so a halt blocks acceptance at once.
  assign req_ready = ready_q & ~hlt;
  assign accept    = req_valid & req_ready;
  assign req_bad   = (req_src == req_dst) | ~IDX_OK[req_src] | ~IDX_OK[req_dst];

  assign out_en    = out_en_q;
  assign load_en   = load_en_q;
  assign last_data = last_data_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      out_en_q    <= '0;
      load_en_q   <= '0;
      last_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      out_en_q    <= out_en_d;
      load_en_q   <= load_en_d;
      last_data_q <= last_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  // Next state and next registered outputs; while halted everything holds its value.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    out_en_d    = out_en_q;
    load_en_d   = load_en_q;
    last_data_d = last_data_q;
    done_d      = done_q;
    err_d       = err_q;
    ready_d     = ready_q;

    if (!hlt) begin
      done_d = 1'b0;
      err_d  = 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              err_d = 1'b1;
            end else begin
              state_d = DRIVE;
              src_d   = req_src;
              dst_d   = req_dst;
            end
          end
        end
        DRIVE: begin
          if (tick) state_d = LATCH;
        end
        LATCH: begin
          if (tick) begin
            state_d     = HOLD;
            last_data_d = bus_in;
          end
        end
        HOLD: begin
          if (tick) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Strobes follow the state being entered so they change on the same edge as the state.
      out_en_d  = '0;
      load_en_d = '0;
      case (state_d)
        DRIVE, HOLD: begin
          out_en_d = onehot(src_d);
        end
        LATCH: begin
          out_en_d  = onehot(src_d);
          load_en_d = onehot(dst_d);
        end
        DONE: begin
          done_d = 1'b1;
        end
        default: begin
        end
      endcase

      // A rejected request keeps ready low for the err cycle.
      ready_d = (state_d == IDLE) && !err_d;
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl: nominal transfer, reject, halt, async reset,
// back-to-back requests and a 3-register instance for out-of-range selects.
module tb_bus_transfer_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       hlt;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_src;
  logic [1:0] req_dst;
  logic [3:0] bus_in;
  logic [3:0] out_en;
  logic [3:0] load_en;
  logic [3:0] last_data;
  logic       done;
  logic       err;

  logic       req_valid3;
  logic       req_ready3;
  logic [1:0] req_src3;
  logic [1:0] req_dst3;
  logic [2:0] out_en3;
  logic [2:0] load_en3;
  logic [3:0] last_data3;
  logic       done3;
  logic       err3;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int viol_cnt = 0;
  int done_before;

  bus_transfer_ctrl #(.NUM_REGS(4), .SEL_W(2), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .hlt(hlt),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_dst(req_dst),
    .bus_in(bus_in), .out_en(out_en), .load_en(load_en), .last_data(last_data),
    .done(done), .err(err)
  );

  bus_transfer_ctrl #(.NUM_REGS(3), .SEL_W(2), .DATA_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .hlt(hlt),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_src(req_src3), .req_dst(req_dst3),
    .bus_in(bus_in), .out_en(out_en3), .load_en(load_en3), .last_data(last_data3),
    .done(done3), .err(err3)
  );

  always #5 clk = ~clk;

  // Strobe safety and done-pulse counting, sampled at every clock edge.
  always @(posedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if ((|load_en && !(|out_en)) || (out_en & load_en) != 4'b0 ||
        $countones(out_en) > 1 || $countones(load_en) > 1)
      viol_cnt = viol_cnt + 1;
    if ((|load_en3 && !(|out_en3)) || (out_en3 & load_en3) != 3'b0)
      viol_cnt = viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Three idle clocks followed by one tick clock: a tick every 4 clks.
  task automatic do_tick();
    cyc(3);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic request(input logic [1:0] s, input logic [1:0] d);
    req_src   = s;
    req_dst   = d;
    req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; tick = 1'b0; hlt = 1'b0;
    req_valid = 1'b0; req_src = 2'd0; req_dst = 2'd0; bus_in = 4'h0;
    req_valid3 = 1'b0; req_src3 = 2'd0; req_dst3 = 2'd0;

    cyc(2);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_out_en", 32'(out_en), 32'h0);
    check("rst_load_en", 32'(load_en), 32'h0);
    check("rst_last_data", 32'(last_data), 32'h0);
    check("rst_done_err", 32'({done, err}), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // 1: nominal transfer 0 -> 2
    bus_in = 4'hA;
    request(2'd0, 2'd2);
    check("t1_drive_out", 32'(out_en), 32'b0001);
    check("t1_drive_load", 32'(load_en), 32'b0000);
    check("t1_busy_ready", 32'(req_ready), 32'd0);
    cyc(2);
    check("t1_settle_out", 32'(out_en), 32'b0001);
    do_tick();
    check("t1_latch_out", 32'(out_en), 32'b0001);
    check("t1_latch_load", 32'(load_en), 32'b0100);
    do_tick();
    check("t1_hold_out", 32'(out_en), 32'b0001);
    check("t1_hold_load", 32'(load_en), 32'b0000);
    check("t1_last_data", 32'(last_data), 32'hA);
    do_tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_out", 32'(out_en), 32'b0000);
    cyc(1);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_ready_back", 32'(req_ready), 32'd1);

    // 2: src == dst is rejected
    request(2'd1, 2'd1);
    check("t2_err", 32'(err), 32'd1);
    check("t2_no_strobes", 32'({out_en, load_en}), 32'h0);
    cyc(1);
    check("t2_err_pulse", 32'(err), 32'd0);
    check("t2_ready", 32'(req_ready), 32'd1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("t2_idle_tick", 32'({out_en, load_en}), 32'h0);

    // 3: halt during LATCH with ticks present
    bus_in = 4'h3;
    request(2'd1, 2'd3);
    do_tick();
    check("t3_latch_load", 32'(load_en), 32'b1000);
    hlt = 1'b1;
    tick = 1'b1;
    bus_in = 4'hF;
    cyc(10);
    check("t3_hlt_out", 32'(out_en), 32'b0010);
    check("t3_hlt_load", 32'(load_en), 32'b1000);
    check("t3_hlt_data", 32'(last_data), 32'hA);
    check("t3_hlt_ready", 32'(req_ready), 32'd0);
    hlt = 1'b0;
    tick = 1'b0;
    bus_in = 4'h3;
    cyc(2);
    check("t3_resume_wait", 32'(load_en), 32'b1000);
    do_tick();
    check("t3_data", 32'(last_data), 32'h3);
    do_tick();
    check("t3_done", 32'(done), 32'd1);
    cyc(1);

    // 4: async reset in HOLD, then a fresh transfer
    done_before = done_cnt;
    bus_in = 4'h7;
    request(2'd2, 2'd0);
    do_tick();
    do_tick();
    check("t4_hold_out", 32'(out_en), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("t4_rst_strobes", 32'({out_en, load_en}), 32'h0);
    check("t4_rst_data", 32'(last_data), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("t4_no_done", 32'(done_cnt - done_before), 32'd0);
    bus_in = 4'h9;
    request(2'd0, 2'd1);
    do_tick();
    do_tick();
    do_tick();
    check("t4_new_done", 32'(done), 32'd1);
    check("t4_new_data", 32'(last_data), 32'h9);
    cyc(1);

    // 5: back-to-back with req_valid held across DONE
    done_before = done_cnt;
    bus_in = 4'h5;
    req_src = 2'd0;
    req_dst = 2'd3;
    req_valid = 1'b1;
    cyc(1);
    req_src = 2'd3;
    req_dst = 2'd1;
    check("t5_first_out", 32'(out_en), 32'b0001);
    do_tick();
    check("t5_first_load", 32'(load_en), 32'b1000);
    do_tick();
    do_tick();
    check("t5_first_done", 32'(done), 32'd1);
    cyc(1);
    check("t5_idle_ready", 32'(req_ready), 32'd1);
    cyc(1);
    req_valid = 1'b0;
    check("t5_second_out", 32'(out_en), 32'b1000);
    do_tick();
    check("t5_second_load", 32'(load_en), 32'b0010);
    do_tick();
    do_tick();
    check("t5_second_done", 32'(done), 32'd1);
    cyc(1);
    check("t5_done_count", 32'(done_cnt - done_before), 32'd2);
    check("t5_data", 32'(last_data), 32'h5);

    // 6: out-of-range source on a 3-register instance
    req_src3 = 2'd3;
    req_dst3 = 2'd0;
    req_valid3 = 1'b1;
    cyc(1);
    req_valid3 = 1'b0;
    check("t6_err", 32'(err3), 32'd1);
    check("t6_no_strobes", 32'({out_en3, load_en3}), 32'h0);
    cyc(1);
    check("t6_err_pulse", 32'(err3), 32'd0);
    check("t6_ready", 32'(req_ready3), 32'd1);
    check("t6_done3", 32'(done3), 32'd0);

    check("strobe_rules", 32'(viol_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
